// File: rtl/conv_encoder_tx_if.sv
// Handshake bundle between the bit source, the encoder and the downstream mapper.
interface conv_encoder_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic [1:0] rate_sel;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] sym;
    logic [1:0] keep;
    logic       out_last;
    logic       busy;

    // Source/sink side: drives data in, accepts symbols out.
    modport master (
        output in_valid, in_bit, in_last, rate_sel, out_ready,
        input  in_ready, out_valid, sym, keep, out_last, busy
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_bit, in_last, rate_sel, out_ready,
        output in_ready, out_valid, sym, keep, out_last, busy
    );
endinterface

// File: rtl/conv_encoder_tx.sv
// K=7 rate-1/2 convolutional encoder (g0=133, g1=171) with 2/3 and 3/4
// puncture masks and zero-tail insertion; one {A,B} symbol per cycle.
module conv_encoder_tx #(
    parameter int unsigned TAIL_LEN = 6,
    parameter int unsigned K        = 7
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    conv_encoder_tx_if.slave  bus
);

    localparam int unsigned SW       = K - 1;
    localparam int unsigned TCW      = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam logic        HAS_TAIL = (TAIL_LEN != 0);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;

    state_t          state_q;
    logic [SW-1:0]   sreg_q;
    logic [1:0]      phase_q;
    logic [TCW-1:0]  tail_cnt_q;
    logic [1:0]      rate_q;
    logic            out_valid_q;
    logic [1:0]      sym_q;
    logic [1:0]      keep_q;
    logic            out_last_q;
    logic            busy_q;

    logic            load_c;
    logic            in_ready_c;
    logic            accept_c;
    logic            frame_start_c;
    logic            tail_last_c;
    logic [SW-1:0]   enc_sreg;
    logic            enc_b;
    logic [1:0]      enc_rate;
    logic [1:0]      enc_phase;
    logic [1:0]      period;
    logic [1:0]      phase_inc;
    logic [1:0]      sym_d;
    logic [1:0]      keep_d;
    logic [1:0]      phase_d;
    logic [SW-1:0]   sreg_d;

    // Handshake, encoder taps and puncture mask for the symbol that would load now.
    // In IDLE/DONE the next accepted bit opens a frame, so it encodes from a
    // cleared register with phase 0 and the live rate_sel.
    always_comb begin
        load_c        = ~out_valid_q | bus.out_ready;
        in_ready_c    = load_c & (state_q != TAIL);
        accept_c      = bus.in_valid & in_ready_c;
        frame_start_c = (state_q == IDLE) || (state_q == DONE);
        tail_last_c   = (tail_cnt_q == TCW'(TAIL_LEN - 1));

        enc_sreg  = frame_start_c ? '0 : sreg_q;
        enc_b     = (state_q == TAIL) ? 1'b0 : bus.in_bit;
        enc_rate  = frame_start_c ? bus.rate_sel : rate_q;
        enc_phase = frame_start_c ? 2'd0 : phase_q;

        sym_d  = {enc_b ^ enc_sreg[1] ^ enc_sreg[2] ^ enc_sreg[4] ^ enc_sreg[5],
                  enc_b ^ enc_sreg[0] ^ enc_sreg[1] ^ enc_sreg[2] ^ enc_sreg[5]};
        sreg_d = {enc_sreg[SW-2:0], enc_b};

        period = 2'd1;
        keep_d = 2'b11;
        case (enc_rate)
            2'b01: begin
                period = 2'd2;
                keep_d = (enc_phase == 2'd0) ? 2'b11 : 2'b10;
            end
            2'b10: begin
                period = 2'd3;
                case (enc_phase)
                    2'd0:    keep_d = 2'b11;
                    2'd1:    keep_d = 2'b10;
                    default: keep_d = 2'b01;
                endcase
            end
            default: begin
                period = 2'd1;
                keep_d = 2'b11;
            end
        endcase

        phase_inc = enc_phase + 2'd1;
        phase_d   = (phase_inc == period) ? 2'd0 : phase_inc;
    end

    // Frame FSM, shift register and the single registered output stage.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            phase_q     <= 2'd0;
            tail_cnt_q  <= '0;
            rate_q      <= 2'b00;
            out_valid_q <= 1'b0;
            sym_q       <= 2'b00;
            keep_q      <= 2'b00;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else if (state_q == TAIL) begin
            if (load_c) begin
                out_valid_q <= 1'b1;
                sym_q       <= sym_d;
                keep_q      <= keep_d;
                phase_q     <= phase_d;
                sreg_q      <= sreg_d;
                out_last_q  <= tail_last_c;
                tail_cnt_q  <= tail_cnt_q + TCW'(1);
                if (tail_last_c) begin
                    state_q <= DONE;
                end
            end
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            sym_q       <= sym_d;
            keep_q      <= keep_d;
            phase_q     <= phase_d;
            sreg_q      <= sreg_d;
            if (frame_start_c) begin
                rate_q <= bus.rate_sel;
                busy_q <= 1'b1;
            end
            if (bus.in_last) begin
                tail_cnt_q <= '0;
                out_last_q <= ~HAS_TAIL;
                state_q    <= HAS_TAIL ? TAIL : DONE;
            end else begin
                out_last_q <= 1'b0;
                state_q    <= DATA;
            end
        end else if (load_c) begin
            out_valid_q <= 1'b0;
            if (state_q == DONE) begin
                busy_q  <= 1'b0;
                sreg_q  <= '0;
                state_q <= IDLE;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.sym       = sym_q;
    assign bus.keep      = keep_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Bench for conv_encoder_tx: polynomial reference model plus scoreboard,
// with literal impulse / puncture-pattern expectations.
module tb_conv_encoder_tx;

    localparam int unsigned TAIL_LEN = 6;
    localparam logic [6:0]  G0 = 7'o133;
    localparam logic [6:0]  G1 = 7'o171;

    typedef struct packed {
        logic [1:0] sym;
        logic [1:0] keep;
        logic       last;
    } exp_t;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    conv_encoder_tx_if bus ();

    conv_encoder_tx #(.TAIL_LEN(TAIL_LEN), .K(7)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    exp_t        exp_q[$];
    logic [1:0]  cap_sym[$];
    logic [1:0]  cap_keep[$];
    logic        cap_last[$];
    int unsigned done_cyc_q[$];

    bit          fr_bits[$];
    logic [1:0]  fr_rsel[$];
    int unsigned first_acc_cyc;

    bit          bp_rand = 1'b0;
    int          stall_n = 0;
    bit          hold_v  = 1'b0;
    logic [4:0]  hold_val;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [1:0] keep_for(input logic [1:0] r, input int unsigned idx);
        case (r)
            2'b01:   return (idx % 2 == 0) ? 2'b11 : 2'b10;
            2'b10: begin
                if (idx % 3 == 0)      return 2'b11;
                else if (idx % 3 == 1) return 2'b10;
                else                   return 2'b01;
            end
            default: return 2'b11;
        endcase
    endfunction

    // Expected symbols of the frame in fr_bits: parity of the 7-bit window
    // against each generator, keep chosen by symbol index within the frame.
    function automatic void model_frame();
        logic [6:0]  h;
        logic [1:0]  r;
        int unsigned n;
        int unsigned total;
        logic        b;
        exp_t        e;
        h     = '0;
        r     = fr_rsel[0];
        n     = fr_bits.size();
        total = n + TAIL_LEN;
        for (int unsigned i = 0; i < total; i++) begin
            b      = (i < n) ? fr_bits[i] : 1'b0;
            h      = {b, h[6:1]};
            e.sym  = {^(h & G0), ^(h & G1)};
            e.keep = keep_for(r, i);
            e.last = (i == total - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Scoreboard and hold-stability monitor.
    always @(negedge HCLK) begin
        exp_t e;
        if (!HRESETn) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_payload", 32'({bus.sym, bus.keep, bus.out_last}), 32'(hold_val));
            end
            hold_v   = bus.out_valid & ~bus.out_ready;
            hold_val = {bus.sym, bus.keep, bus.out_last};
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_symbol actual=%0h required=none (cycle %0d)",
                             {bus.sym, bus.keep, bus.out_last}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("symbol", 32'({bus.sym, bus.keep, bus.out_last}), 32'(e));
                end
                check("busy_in_frame", 32'(bus.busy), 32'd1);
                cap_sym.push_back(bus.sym);
                cap_keep.push_back(bus.keep);
                cap_last.push_back(bus.out_last);
                if (bus.out_last) done_cyc_q.push_back(cyc);
            end
        end
    end

    // Downstream ready: always 1, random, or a forced stall window.
    always @(posedge HCLK) begin
        #1;
        if (stall_n > 0) begin
            bus.out_ready = 1'b0;
            stall_n--;
        end else begin
            bus.out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic clear_caps();
        cap_sym.delete();
        cap_keep.delete();
        cap_last.delete();
        done_cyc_q.delete();
    endtask

    // Drives fr_bits with per-bit rate_sel; entered between posedge and negedge.
    task automatic send_frame();
        int  n;
        bit  done;
        bit  abort;
        int  waitc;
        n     = fr_bits.size();
        abort = 1'b0;
        for (int i = 0; i < n && !abort; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = fr_bits[i];
            bus.in_last  = (i == n - 1);
            bus.rate_sel = fr_rsel[i];
            done  = 1'b0;
            waitc = 0;
            while (!done && !abort) begin
                @(negedge HCLK);
                if (bus.in_ready && HRESETn) begin
                    done = 1'b1;
                    if (i == 0) first_acc_cyc = cyc;
                end else if (++waitc > 2000) begin
                    checks++;
                    failures++;
                    $display("FAIL in_ready_timeout actual=0 required=1 (bit %0d)", i);
                    abort = 1'b1;
                end
                @(posedge HCLK);
                #1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge HCLK);
            t++;
        end
        #2;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, "_valid_end"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic set_frame(input int n, input logic [1:0] r, input bit rnd);
        fr_bits.delete();
        fr_rsel.delete();
        for (int i = 0; i < n; i++) begin
            fr_bits.push_back(rnd ? bit'($urandom & 1) : 1'b1);
            fr_rsel.push_back(r);
        end
    endtask

    // Literal impulse response of the 133/171 code: 7 symbols from offset.
    task automatic check_impulse(input string tag, input int off);
        logic [6:0] av, bv, lv;
        logic [13:0] kv;
        av = '0; bv = '0; lv = '0; kv = '0;
        check({tag, "_count"}, 32'(cap_sym.size()), 32'(off + 7));
        for (int i = 0; i < 7; i++) begin
            if (off + i < cap_sym.size()) begin
                av[6-i]        = cap_sym[off+i][1];
                bv[6-i]        = cap_sym[off+i][0];
                lv[6-i]        = cap_last[off+i];
                kv[13-2*i -: 2] = cap_keep[off+i];
            end
        end
        check({tag, "_A"}, 32'(av), 32'(7'b1011011));
        check({tag, "_B"}, 32'(bv), 32'(7'b1111001));
        check({tag, "_keep"}, 32'(kv), 32'(14'h3fff));
        check({tag, "_last"}, 32'(lv), 32'(7'b0000001));
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [23:0] k24;
        logic [15:0] k16;
        logic [27:0] k28;

        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.rate_sel  = 2'b00;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge HCLK);
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sym", 32'(bus.sym), 32'd0);
        check("rst_keep", 32'(bus.keep), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Impulse, rate 1/2
        clear_caps();
        set_frame(1, 2'b00, 1'b0);
        model_frame();
        send_frame();
        wait_drain("impulse");
        check_impulse("impulse", 0);

        // Rate 3/4, six ones, then a short frame to show the phase restarts
        clear_caps();
        set_frame(6, 2'b10, 1'b0);
        model_frame();
        send_frame();
        wait_drain("r34");
        k24 = '0;
        for (int i = 0; i < 12 && i < cap_keep.size(); i++) k24[23-2*i -: 2] = cap_keep[i];
        check("r34_count", 32'(cap_keep.size()), 32'd12);
        check("r34_keep", 32'(k24), 32'({4{6'b111001}}));
        clear_caps();
        set_frame(2, 2'b10, 1'b1);
        model_frame();
        send_frame();
        wait_drain("r34b");
        k16 = '0;
        for (int i = 0; i < 8 && i < cap_keep.size(); i++) k16[15-2*i -: 2] = cap_keep[i];
        check("r34b_keep", 32'(k16), 32'(16'b1110011110011110));

        // rate_sel moves 01 -> 10 mid-frame; 2/3 pattern must persist
        clear_caps();
        set_frame(8, 2'b01, 1'b1);
        for (int i = 3; i < 8; i++) fr_rsel[i] = 2'b10;
        model_frame();
        send_frame();
        wait_drain("rchg");
        k28 = '0;
        for (int i = 0; i < 14 && i < cap_keep.size(); i++) k28[27-2*i -: 2] = cap_keep[i];
        check("rchg_keep", 32'(k28), 32'({7{4'b1110}}));

        // 200-bit random frame under random backpressure plus a 5-cycle stall
        clear_caps();
        bp_rand = 1'b1;
        set_frame(200, 2'($urandom_range(0, 3)), 1'b1);
        model_frame();
        fork
            send_frame();
            begin
                repeat (40) @(posedge HCLK);
                stall_n = 5;
                repeat (5) begin
                    @(negedge HCLK);
                    check("stall_in_ready", 32'(bus.in_ready), 32'(!bus.out_valid));
                end
            end
        join
        wait_drain("bp");
        check("bp_count", 32'(cap_sym.size()), 32'(200 + TAIL_LEN));

        // Random frames of random length and rate
        for (int f = 0; f < 6; f++) begin
            set_frame($urandom_range(1, 40), 2'($urandom_range(0, 3)), 1'b1);
            model_frame();
            send_frame();
            wait_drain("rand");
        end
        bp_rand = 1'b0;

        // Async reset while the tail is being emitted
        set_frame(3, 2'b00, 1'b1);
        model_frame();
        send_frame();
        @(posedge HCLK);
        #3;
        HRESETn = 1'b0;
        #1;
        check("rst_tail_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_tail_busy", 32'(bus.busy), 32'd0);
        check("rst_tail_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        @(negedge HCLK);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        clear_caps();
        set_frame(1, 2'b00, 1'b0);
        model_frame();
        send_frame();
        wait_drain("post_rst");
        check_impulse("post_rst", 0);

        // Back-to-back frames: frame 2 starts on frame 1's out_last handshake
        clear_caps();
        set_frame(10, 2'b00, 1'b1);
        model_frame();
        send_frame();
        set_frame(1, 2'b00, 1'b0);
        model_frame();
        send_frame();
        wait_drain("b2b");
        check("b2b_done_seen", 32'(done_cyc_q.size() >= 1), 32'd1);
        if (done_cyc_q.size() >= 1)
            check("b2b_first_bit_cycle", 32'(first_acc_cyc), 32'(done_cyc_q[0]));
        check_impulse("b2b_f2", 10 + TAIL_LEN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_encoder_tx.md
Name: conv_encoder_tx

Overview:
- Transmit-side convolutional encoder for the WiFi PHY. It pairs with the receive-side Viterbi decoder and its hard branch-distance units.
- Function: encodes a serial data bit stream with the 802.11 K=7, rate-1/2 code (g0=133 octal, g1=171 octal), optionally punctures to rate 2/3 or 3/4, and appends 6 zero tail bits per frame.
- Output: one 2-bit symbol per cycle, {A,B} on sym[1:0]. A per-bit keep mask marks punctured positions; the interleaver/mapper downstream consumes only the kept bits.

Parameters:
- TAIL_LEN, 6, number of zero tail bits appended after in_last (0 disables tail insertion).
- K, 7, constraint length (fixed at 7; the generator polynomials assume it).

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  asynchronous active-low reset
- in_valid  input  1  in_bit is valid
- in_ready  output  1  encoder accepts in_bit this cycle
- in_bit  input  1  data bit
- in_last  input  1  marks the final data bit of the frame
- rate_sel  input  2  00=1/2, 01=2/3, 10=3/4, 11=1/2; sampled with the first bit of each frame
- out_valid  output  1  sym/keep/out_last are valid
- out_ready  input  1  downstream accepts the symbol
- sym  output  2  sym[1]=A (g0), sym[0]=B (g1)
- keep  output  2  keep[1] qualifies A, keep[0] qualifies B; 1 = transmit
- out_last  output  1  final symbol of the frame, including the tail
- busy  output  1  frame in progress (from first accepted bit to acceptance of the out_last symbol)

Behaviour:
- Reset (async, HRESETn=0):
  - Shift register = 0, state = IDLE, puncture phase = 0, tail counter = 0.
  - out_valid = 0, sym = 00, keep = 00, out_last = 0, busy = 0, latched rate = 00.
- Encoding (b = current input, s[0] = previous bit ... s[5] = oldest):
  - A = b^s[1]^s[2]^s[4]^s[5]
  - B = b^s[0]^s[1]^s[2]^s[5]
  - On each encode step: s <= {s[4:0], b}.
- Output register:
  - Single output stage; 1-cycle latency from input acceptance to out_valid.
  - Load condition: load = ~out_valid | out_ready.
  - in_ready = load & (state != TAIL).
  - On a load with no new symbol, out_valid drops to 0.
  - Held outputs are stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: waiting for the first bit. On in_valid & in_ready: latch rate_sel, phase = 0, encode, busy = 1, go to DATA. If in_last is also set, go to TAIL instead (or DONE when TAIL_LEN=0).
  - DATA: encode each accepted bit. When in_last is accepted, go to TAIL (or DONE when TAIL_LEN=0); the symbol for that bit has out_last=1 only when TAIL_LEN=0.
  - TAIL: in_ready=0. Encode b=0 on every load, TAIL_LEN times. The last tail symbol has out_last=1. Then go to DONE.
  - DONE: wait for the out_last symbol to be accepted (out_valid & out_ready), then busy=0, shift register cleared to 0, go to IDLE. A new frame's first bit may be accepted in that same cycle.
- Puncturing: phase advances on every encoded symbol (data and tail). keep by rate:
  - 1/2: always 11.
  - 2/3 (period 2): phase 0 -> 11, phase 1 -> 10.
  - 3/4 (period 3): phase 0 -> 11, phase 1 -> 10, phase 2 -> 01.
  - Phase wraps at the period and restarts at 0 each frame.
- Boundary rules:
  - rate_sel changes mid-frame are ignored.
  - Back-to-back frames have no idle cycle forced beyond the DONE handshake.
  - HRESETn asserted mid-frame aborts immediately to reset values; no partial tail is emitted.

Test Plan:
- Impulse, rate 1/2, TAIL_LEN=6, frame = single bit 1 with in_last, out_ready=1 -> 7 symbols. A = 1,0,1,1,0,1,1; B = 1,1,1,1,0,0,1; keep = 11 throughout; out_last only on symbol 7; busy falls after it.
- Rate 3/4, 6 data bits all 1, TAIL_LEN=6 -> 12 symbols. keep repeats 11,10,01 four times; phase resets to 0 on the next frame.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame -> sym/keep stable and in_ready=0 during the stall; no bit lost or duplicated versus the reference model over a 200-bit random frame.
- rate_sel changed from 01 to 10 mid-frame -> pattern stays 11,10 (2/3) until the frame ends.
- Async reset asserted during TAIL -> out_valid=0, busy=0 immediately. The next frame's impulse response matches scenario 1 (shift register cleared).
- Back-to-back frames with out_ready=1, rate 1/2 -> the first bit of frame 2 is accepted in the same cycle frame 1's out_last symbol is accepted. Frame 2's output matches an independent encode from the zero state.
